// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: operation, size, signedness and FSM
// state enums, plus helpers for store lane placement and alignment checks.
package load_store_unit_pkg;

  typedef logic signed [31:0] int32_t;

  typedef enum logic {UNSIGNED = 1'b0, SIGNED = 1'b1} signedness_t;

  typedef enum logic {MEM_LOAD = 1'b0, MEM_STORE = 1'b1} mem_op_t;

  typedef enum logic [1:0] {SIZE_BYTE = 2'd0, SIZE_HALF = 2'd1, SIZE_WORD = 2'd2} mem_size_t;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} lsu_state_t;

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
    case (size)
      SIZE_HALF: return offset[0];
      SIZE_WORD: return offset != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input mem_size_t size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 4'b0001 << offset;
      SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  // Sub-word stores are copied into every lane so the bus only needs byte enables.
  function automatic logic [31:0] replicate(input mem_size_t size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: return {4{data[7:0]}};
      SIZE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Load lane selection: picks the byte/half addressed by the offset out of the
// bus word and sign- or zero-extends it to 32 bits.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0]  mem_rdata,
  input  logic [1:0]   offset,
  input  mem_size_t    size,
  input  signedness_t  signedness,
  output int32_t       load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        ext_bit;

  always_comb begin
    byte_lane = 8'(mem_rdata >> {offset, 3'b000});
    half_lane = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext_bit   = 1'b0;
    load_data = mem_rdata;
    case (size)
      SIZE_BYTE: begin
        ext_bit   = (signedness == SIGNED) & byte_lane[7];
        load_data = {{24{ext_bit}}, byte_lane};
      end
      SIZE_HALF: begin
        ext_bit   = (signedness == SIGNED) & half_lane[15];
        load_data = {{16{ext_bit}}, half_lane};
      end
      default: load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-access load/store unit: registers a request, drives one bus strobe
// until accepted or timed out, then pulses done with an optional fault.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  mem_op_t      op,
  input  mem_size_t    size,
  input  signedness_t  signedness,
  input  int32_t       addr,
  input  int32_t       store_data,
  output logic         ready,
  output logic         done,
  output logic         fault,
  output int32_t       load_data,
  output logic [31:0]  mem_addr,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_byteen,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_wait
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t  state, next_state;
  mem_op_t     op_q;
  mem_size_t   size_q;
  signedness_t sign_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  byteen_q;
  logic [CNT_W-1:0] stall_cnt;
  logic        fault_q;
  int32_t      load_q;
  int32_t      aligned;
  logic        misaligned;
  logic        stall_limit;

  assign misaligned  = is_misaligned(size, addr[1:0]);
  assign stall_limit = (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  load_align u_load_align (
    .mem_rdata  (mem_rdata),
    .offset     (addr_q[1:0]),
    .size       (size_q),
    .signedness (sign_q),
    .load_data  (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = misaligned ? DONE : REQ;
      REQ:  if (!mem_wait || stall_limit) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Store lanes are computed at capture so the bus side sees only registered values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= MEM_LOAD;
      size_q    <= SIZE_BYTE;
      sign_q    <= UNSIGNED;
      addr_q    <= '0;
      wdata_q   <= '0;
      byteen_q  <= '0;
      stall_cnt <= '0;
      fault_q   <= 1'b0;
      load_q    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q      <= op;
          size_q    <= size;
          sign_q    <= signedness;
          addr_q    <= addr;
          wdata_q   <= replicate(size, store_data);
          byteen_q  <= byte_enable(size, addr[1:0]);
          stall_cnt <= '0;
          fault_q   <= misaligned;
          load_q    <= '0;
        end
        REQ: begin
          if (!mem_wait) begin
            fault_q <= 1'b0;
            load_q  <= (op_q == MEM_LOAD) ? aligned : '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_limit) begin
              fault_q <= 1'b1;
              load_q  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ready      = (state == IDLE);
    done       = (state == DONE);
    fault      = done & fault_q;
    load_data  = done ? load_q : '0;
    mem_read   = (state == REQ) && (op_q == MEM_LOAD);
    mem_write  = (state == REQ) && (op_q == MEM_STORE);
    mem_byteen = (state == REQ) ? byteen_q : 4'b0000;
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_wdata  = wdata_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: each request pushes its expected
// completion (fault, data, cycle) to a queue that a done monitor drains.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  mem_op_t     op = MEM_LOAD;
  mem_size_t   size = SIZE_BYTE;
  signedness_t signedness = UNSIGNED;
  int32_t      addr = '0;
  int32_t      store_data = '0;
  logic        ready, done, fault;
  int32_t      load_data;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata = '0;
  logic        mem_wait = 1'b0;

  load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .size       (size),
    .signedness (signedness),
    .addr       (addr),
    .store_data (store_data),
    .ready      (ready),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_byteen (mem_byteen),
    .mem_rdata  (mem_rdata),
    .mem_wait   (mem_wait)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        fault;
    logic [31:0] data;
    int          cycle;
  } resp_t;

  resp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_read || mem_write)
      check_output("strobe_exclusive", 32'(mem_read & mem_write), 32'd0);
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pending request", cyc);
      end else begin
        resp_t e;
        e = sb.pop_front();
        check_output("done_fault", 32'(fault), 32'(e.fault));
        check_output("load_data", load_data, e.data);
        check_output("done_cycle", 32'(cyc), 32'(e.cycle));
      end
    end
  end

  task automatic apply_stimulus(input mem_op_t o, input mem_size_t s, input signedness_t g,
                                input logic [31:0] a, input logic [31:0] d, input bit expect_resp,
                                input logic exp_fault, input logic [31:0] exp_data, input int exp_lat);
    resp_t r;
    @(negedge clk);
    op = o;
    size = s;
    signedness = g;
    addr = a;
    store_data = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_resp) begin
      r.fault = exp_fault;
      r.data  = exp_data;
      r.cycle = cyc + exp_lat;
      sb.push_back(r);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 50);
    check_output("return_to_idle", 32'(ready), 32'd1);
  endtask

  task automatic check_strobes(input string tag, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    check_output({tag, "_read"}, 32'(mem_read), 32'(rd));
    check_output({tag, "_write"}, 32'(mem_write), 32'(wr));
    check_output({tag, "_addr"}, mem_addr, a);
    check_output({tag, "_byteen"}, 32'(mem_byteen), 32'(be));
    if (wr) check_output({tag, "_wdata"}, mem_wdata, wd);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int reads;

    repeat (2) @(negedge clk);
    check_output("rst_ready", 32'(ready), 32'd1);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_load_data", load_data, 32'd0);
    check_strobes("rst", 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
    check_output("rst_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    // Store byte into the top lane.
    apply_stimulus(MEM_STORE, SIZE_BYTE, UNSIGNED, 32'h1003, 32'h0000_00AB, 1, 1'b0, 32'h0, 1);
    @(negedge clk);
    check_strobes("st_byte3", 1'b0, 1'b1, 32'h1000, 4'b1000, 32'hABAB_ABAB);
    wait_idle();

    apply_stimulus(MEM_STORE, SIZE_BYTE, UNSIGNED, 32'h0000, 32'h1234_5655, 1, 1'b0, 32'h0, 1);
    @(negedge clk);
    check_strobes("st_byte0", 1'b0, 1'b1, 32'h0000, 4'b0001, 32'h5555_5555);
    wait_idle();

    apply_stimulus(MEM_STORE, SIZE_HALF, UNSIGNED, 32'h0022, 32'h1234_BEEF, 1, 1'b0, 32'h0, 1);
    @(negedge clk);
    check_strobes("st_half2", 1'b0, 1'b1, 32'h0020, 4'b1100, 32'hBEEF_BEEF);
    wait_idle();

    mem_rdata = 32'h8001_1234;
    apply_stimulus(MEM_LOAD, SIZE_HALF, SIGNED, 32'h2002, 32'h0, 1, 1'b0, 32'hFFFF_8001, 1);
    @(negedge clk);
    check_strobes("ld_half", 1'b1, 1'b0, 32'h2000, 4'b1100, 32'h0);
    wait_idle();
    apply_stimulus(MEM_LOAD, SIZE_HALF, UNSIGNED, 32'h2002, 32'h0, 1, 1'b0, 32'h0000_8001, 1);
    wait_idle();
    apply_stimulus(MEM_LOAD, SIZE_HALF, SIGNED, 32'h2000, 32'h0, 1, 1'b0, 32'h0000_1234, 1);
    wait_idle();

    mem_rdata = 32'h0000_F000;
    apply_stimulus(MEM_LOAD, SIZE_BYTE, SIGNED, 32'h0011, 32'h0, 1, 1'b0, 32'hFFFF_FFF0, 1);
    wait_idle();
    mem_rdata = 32'h9A00_0000;
    apply_stimulus(MEM_LOAD, SIZE_BYTE, UNSIGNED, 32'h0013, 32'h0, 1, 1'b0, 32'h0000_009A, 1);
    wait_idle();
    mem_rdata = 32'hDEAD_BEEF;
    apply_stimulus(MEM_LOAD, SIZE_WORD, SIGNED, 32'h0044, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, 1);
    @(negedge clk);
    check_strobes("ld_word", 1'b1, 1'b0, 32'h0044, 4'b1111, 32'h0);
    wait_idle();

    // Misaligned requests fault in the cycle after start with no bus strobe.
    apply_stimulus(MEM_LOAD, SIZE_WORD, UNSIGNED, 32'h3001, 32'h0, 1, 1'b1, 32'h0, 0);
    @(negedge clk);
    check_output("misal_word_no_read", 32'(mem_read), 32'd0);
    wait_idle();
    apply_stimulus(MEM_STORE, SIZE_HALF, UNSIGNED, 32'h0005, 32'hFFFF, 1, 1'b1, 32'h0, 0);
    @(negedge clk);
    check_output("misal_half_no_write", 32'(mem_write), 32'd0);
    wait_idle();

    // Bus held stalled: strobe for TIMEOUT cycles, then faulting done.
    mem_wait = 1'b1;
    mem_rdata = 32'h5A5A_5A5A;
    apply_stimulus(MEM_LOAD, SIZE_WORD, UNSIGNED, 32'h0040, 32'h0, 1, 1'b1, 32'h0, TIMEOUT);
    reads = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_read) reads++;
    end
    check_output("timeout_read_cycles", 32'(reads), 32'(TIMEOUT));
    mem_wait = 1'b0;
    wait_idle();

    // Reset in the second stalled cycle discards the store silently.
    mem_wait = 1'b1;
    apply_stimulus(MEM_STORE, SIZE_WORD, UNSIGNED, 32'h4008, 32'h1122_3344, 0, 1'b0, 32'h0, 0);
    @(negedge clk);
    check_output("rst_mid_write_before", 32'(mem_write), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("rst_mid_write", 32'(mem_write), 32'd0);
    check_output("rst_mid_ready", 32'(ready), 32'd1);
    check_output("rst_mid_byteen", 32'(mem_byteen), 32'd0);
    check_output("rst_mid_addr", mem_addr, 32'd0);
    @(negedge clk);
    check_output("rst_mid_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    mem_wait = 1'b0;
    mem_rdata = 32'h0BAD_F00D;
    apply_stimulus(MEM_LOAD, SIZE_WORD, UNSIGNED, 32'h4000, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 1);
    wait_idle();

    repeat (2) @(negedge clk);
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
